// File: rtl/oflow_score_board_pkg.sv
// Shared definitions for the oflow multi-candidate score board.
//
// Contents:
//   DEF_*       default parameter values used by the score-board modules
//   sb_state_e  sweep controller state (idle / clearing rows)
//   cand_t      one (score, id) candidate at the default field widths
package oflow_score_board_pkg;

    localparam int DEF_ROWS    = 32;
    localparam int DEF_CANDS   = 4;
    localparam int DEF_SCORE_W = 16;
    localparam int DEF_ID_W    = 12;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_CLEAR = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [DEF_SCORE_W-1:0] score;
        logic [DEF_ID_W-1:0]    id;
    } cand_t;

endpackage

// File: rtl/oflow_sb_cand_sel.sv
// Candidate selector for one score-board row.
//
// Picks candidate[ptr] out of a row's packed candidate list. A row that was
// never written, or whose candidates have all been consumed, reports the
// neutral "no candidate" value: score all-ones, ID zero.
//
// Ports:
//   scores    in  CANDS*SCORE_W  candidate scores, candidate 0 in the LSBs
//   ids       in  CANDS*ID_W     candidate IDs, same ordering
//   ptr       in  PTR_W          index of the currently selected candidate
//   valid     in  1              row holds written data
//   exh       in  1              row has run out of candidates
//   sel_score out SCORE_W        selected score
//   sel_id    out ID_W           selected ID
//   exhausted out 1              row is valid but exhausted
module oflow_sb_cand_sel
    import oflow_score_board_pkg::*;
#(
    parameter int CANDS   = DEF_CANDS,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int PTR_W   = $clog2(DEF_CANDS)
) (
    input  logic [CANDS*SCORE_W-1:0] scores,
    input  logic [CANDS*ID_W-1:0]    ids,
    input  logic [PTR_W-1:0]         ptr,
    input  logic                     valid,
    input  logic                     exh,
    output logic [SCORE_W-1:0]       sel_score,
    output logic [ID_W-1:0]          sel_id,
    output logic                     exhausted
);

    // Mux written as a compare loop so a pointer value beyond CANDS-1
    // (only possible for non power-of-two CANDS) falls back to "no candidate".
    always_comb begin
        sel_score = '1;
        sel_id    = '0;
        for (int c = 0; c < CANDS; c++) begin
            if (valid && !exh && (ptr == PTR_W'(c))) begin
                sel_score = scores[c*SCORE_W +: SCORE_W];
                sel_id    = ids[c*ID_W +: ID_W];
            end
        end
    end

    assign exhausted = valid && exh;

endmodule

// File: rtl/oflow_score_board_mc.sv
// Multi-candidate score board for the oflow core.
//
// Each row keeps the best CANDS (score, id) candidates of one detected object
// and a pointer to the candidate currently in use. The conflict resolver can
// advance the pointer past lost candidates; once the last candidate is lost
// the row is flagged exhausted. A frame clear sweeps all rows invalid, one
// row per cycle.
//
// Ports:
//   clk, reset_N            clock, asynchronous active-low reset
//   frame_clear/clear_done  start a clear sweep / one-cycle pulse at its end
//   wr_valid/wr_ready       row-write handshake (wr_row, wr_scores, wr_ids)
//   wr_done                 one-cycle pulse the cycle after an accepted write
//   adv_valid, adv_row      advance the selected candidate of a row
//   cr_row -> cr_score, cr_id, cr_exhausted   conflict-resolver read port
//   buf_row -> buf_id                         buffer read port
//   id_out, id_valid        selected ID / usable flag of every row
module oflow_score_board_mc
    import oflow_score_board_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int CANDS   = DEF_CANDS,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int ROW_W   = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     reset_N,
    input  logic                     frame_clear,
    output logic                     clear_done,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ROW_W-1:0]         wr_row,
    input  logic [CANDS*SCORE_W-1:0] wr_scores,
    input  logic [CANDS*ID_W-1:0]    wr_ids,
    output logic                     wr_done,
    input  logic                     adv_valid,
    input  logic [ROW_W-1:0]         adv_row,
    input  logic [ROW_W-1:0]         cr_row,
    output logic [SCORE_W-1:0]       cr_score,
    output logic [ID_W-1:0]          cr_id,
    output logic                     cr_exhausted,
    input  logic [ROW_W-1:0]         buf_row,
    output logic [ID_W-1:0]          buf_id,
    output logic [ROWS*ID_W-1:0]     id_out,
    output logic [ROWS-1:0]          id_valid
);

    localparam int PTR_W = $clog2(CANDS);

    sb_state_e               state;
    logic [ROW_W-1:0]        clr_cnt;
    logic [CANDS*SCORE_W-1:0] score_mem [ROWS];
    logic [CANDS*ID_W-1:0]    id_mem    [ROWS];
    logic [PTR_W-1:0]        ptr [ROWS];
    logic [ROWS-1:0]         row_valid;
    logic [ROWS-1:0]         row_exh;
    logic                    wr_fire;
    logic                    adv_fire;
    logic                    clearing;

    // A frame_clear in the same cycle blocks writes, so no write can land
    // in a row that the new sweep is about to wipe.
    assign wr_ready = (state == SB_IDLE) && !frame_clear;
    assign wr_fire  = wr_valid && wr_ready;
    assign adv_fire = adv_valid && (state == SB_IDLE);
    // A restart request suppresses the row clear of this cycle; the sweep
    // begins again at row 0 on the following edge.
    assign clearing = (state == SB_CLEAR) && !frame_clear;

    // Sweep controller and handshake pulses.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state      <= SB_IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            wr_done    <= wr_fire;
            clear_done <= 1'b0;
            case (state)
                SB_IDLE: begin
                    if (frame_clear) begin
                        state   <= SB_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                SB_CLEAR: begin
                    if (frame_clear) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == ROW_W'(ROWS - 1)) begin
                        state      <= SB_IDLE;
                        clear_done <= 1'b1;
                        clr_cnt    <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= SB_IDLE;
            endcase
        end
    end

    // Per-row status. Priority: sweep clear, then write (so a write beats a
    // same-row advance), then advance. Advances on rows without a usable
    // candidate are ignored.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            row_valid <= '0;
            row_exh   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                ptr[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (clearing && (clr_cnt == ROW_W'(r))) begin
                    row_valid[r] <= 1'b0;
                    row_exh[r]   <= 1'b0;
                    ptr[r]       <= '0;
                end else if (wr_fire && (wr_row == ROW_W'(r))) begin
                    row_valid[r] <= 1'b1;
                    row_exh[r]   <= 1'b0;
                    ptr[r]       <= '0;
                end else if (adv_fire && (adv_row == ROW_W'(r)) &&
                             row_valid[r] && !row_exh[r]) begin
                    if (ptr[r] == PTR_W'(CANDS - 1)) begin
                        row_exh[r] <= 1'b1;
                    end else begin
                        ptr[r] <= ptr[r] + 1'b1;
                    end
                end
            end
        end
    end

    // Candidate payload; masked by row_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            score_mem[wr_row] <= wr_scores;
            id_mem[wr_row]    <= wr_ids;
        end
    end

    oflow_sb_cand_sel #(
        .CANDS(CANDS), .SCORE_W(SCORE_W), .ID_W(ID_W), .PTR_W(PTR_W)
    ) u_cr_sel (
        .scores    (score_mem[cr_row]),
        .ids       (id_mem[cr_row]),
        .ptr       (ptr[cr_row]),
        .valid     (row_valid[cr_row]),
        .exh       (row_exh[cr_row]),
        .sel_score (cr_score),
        .sel_id    (cr_id),
        .exhausted (cr_exhausted)
    );

    oflow_sb_cand_sel #(
        .CANDS(CANDS), .SCORE_W(SCORE_W), .ID_W(ID_W), .PTR_W(PTR_W)
    ) u_buf_sel (
        .scores    (score_mem[buf_row]),
        .ids       (id_mem[buf_row]),
        .ptr       (ptr[buf_row]),
        .valid     (row_valid[buf_row]),
        .exh       (row_exh[buf_row]),
        .sel_score (),
        .sel_id    (buf_id),
        .exhausted ()
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        oflow_sb_cand_sel #(
            .CANDS(CANDS), .SCORE_W(SCORE_W), .ID_W(ID_W), .PTR_W(PTR_W)
        ) u_row_sel (
            .scores    (score_mem[r]),
            .ids       (id_mem[r]),
            .ptr       (ptr[r]),
            .valid     (row_valid[r]),
            .exh       (row_exh[r]),
            .sel_score (),
            .sel_id    (id_out[r*ID_W +: ID_W]),
            .exhausted ()
        );
        assign id_valid[r] = row_valid[r] && !row_exh[r];
    end

endmodule

// File: tb/tb_oflow_score_board_mc.sv
// Self-checking bench for oflow_score_board_mc (default parameters).
// A behavioural row model produces expected read values, which are queued
// when stimulus is applied and popped/compared against the read ports.
module tb_oflow_score_board_mc;

    localparam int ROWS = 32, CANDS = 4, SCORE_W = 16, ID_W = 12, ROW_W = 5;

    logic                     clk = 1'b0;
    logic                     reset_N;
    logic                     frame_clear;
    logic                     clear_done;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [ROW_W-1:0]         wr_row;
    logic [CANDS*SCORE_W-1:0] wr_scores;
    logic [CANDS*ID_W-1:0]    wr_ids;
    logic                     wr_done;
    logic                     adv_valid;
    logic [ROW_W-1:0]         adv_row;
    logic [ROW_W-1:0]         cr_row;
    logic [SCORE_W-1:0]       cr_score;
    logic [ID_W-1:0]          cr_id;
    logic                     cr_exhausted;
    logic [ROW_W-1:0]         buf_row;
    logic [ID_W-1:0]          buf_id;
    logic [ROWS*ID_W-1:0]     id_out;
    logic [ROWS-1:0]          id_valid;

    oflow_score_board_mc #(
        .ROWS(ROWS), .CANDS(CANDS), .SCORE_W(SCORE_W), .ID_W(ID_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .reset_N(reset_N), .frame_clear(frame_clear),
        .clear_done(clear_done), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_scores(wr_scores), .wr_ids(wr_ids),
        .wr_done(wr_done), .adv_valid(adv_valid), .adv_row(adv_row),
        .cr_row(cr_row), .cr_score(cr_score), .cr_id(cr_id),
        .cr_exhausted(cr_exhausted), .buf_row(buf_row), .buf_id(buf_id),
        .id_out(id_out), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        int               row;
        logic [SCORE_W-1:0] score;
        logic [ID_W-1:0]  id;
        logic             exh;
        logic             idv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [SCORE_W-1:0] m_sc [ROWS][CANDS];
    logic [ID_W-1:0]    m_id [ROWS][CANDS];
    int                 m_ptr [ROWS];
    bit                 m_valid [ROWS];
    bit                 m_exh [ROWS];

    function automatic void model_write(int row);
        m_valid[row] = 1'b1;
        m_exh[row]   = 1'b0;
        m_ptr[row]   = 0;
        for (int c = 0; c < CANDS; c++) begin
            m_sc[row][c] = wr_scores[c*SCORE_W +: SCORE_W];
            m_id[row][c] = wr_ids[c*ID_W +: ID_W];
        end
    endfunction

    function automatic void model_adv(int row);
        if (m_valid[row] && !m_exh[row]) begin
            if (m_ptr[row] == CANDS - 1) m_exh[row] = 1'b1;
            else m_ptr[row] = m_ptr[row] + 1;
        end
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) begin
            m_valid[r] = 1'b0;
            m_exh[r]   = 1'b0;
            m_ptr[r]   = 0;
        end
    endfunction

    function automatic void push_expect(string tag, int row);
        exp_t e;
        e.tag = tag;
        e.row = row;
        if (m_valid[row] && !m_exh[row]) begin
            e.score = m_sc[row][m_ptr[row]];
            e.id    = m_id[row][m_ptr[row]];
        end else begin
            e.score = '1;
            e.id    = '0;
        end
        e.exh = m_valid[row] && m_exh[row];
        e.idv = m_valid[row] && !m_exh[row];
        exp_q.push_back(e);
    endfunction

    // Scores s0, s0+10, s0+20, s0+30; IDs id0 .. id0+3 (candidate 0 first).
    task automatic load_write(input int row, input int s0, input int id0);
        wr_row = ROW_W'(row);
        for (int c = 0; c < CANDS; c++) begin
            wr_scores[c*SCORE_W +: SCORE_W] = SCORE_W'(s0 + 10*c);
            wr_ids[c*ID_W +: ID_W]          = ID_W'(id0 + c);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_ready, wr_done, clear_done, cr_exhausted} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy/done/cdone/exh=%b required 1000",
                     {wr_ready, wr_done, clear_done, cr_exhausted});
        end
        checks++;
        if (cr_score !== 16'hFFFF || cr_id !== 12'd0 || buf_id !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_read: got score=%h id=%h buf=%h required ffff/000/000",
                     cr_score, cr_id, buf_id);
        end
        checks++;
        if (id_valid !== '0 || id_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ids: got id_valid=%h required 0", id_valid);
        end
        @(negedge clk);
        reset_N = 1'b1;
    endtask

    task automatic test_write();
        exp_t e;
        @(negedge clk);
        load_write(3, 10, 5);
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_done: got %b required 1", wr_done);
        end
        wr_valid = 1'b0;
        model_write(3);
        push_expect("write_row3", 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
            #1;
            checks++;
            if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                         e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                         id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done_pulse: got %b required 0", wr_done);
        end
    endtask

    // Five back-to-back advances: ids 6,7,8, then exhausted, then no change.
    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        adv_valid = 1'b1;
        adv_row   = 5'd3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            model_adv(3);
            push_expect($sformatf("advance_%0d", k + 1), 3);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
                #1;
                checks++;
                if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                    !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                    errors++;
                    $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                             e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                             id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
                end
            end
        end
        adv_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        exp_t e;
        // Write and advance on the same row: the write wins.
        @(negedge clk);
        load_write(3, 100, 9);
        wr_valid  = 1'b1;
        adv_valid = 1'b1;
        adv_row   = 5'd3;
        @(posedge clk);
        #1;
        model_adv(3);
        model_write(3);
        wr_valid  = 1'b0;
        adv_valid = 1'b0;
        // Prepare row 2, then write row 1 while advancing row 2.
        @(negedge clk);
        load_write(2, 50, 21);
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        model_write(2);
        @(negedge clk);
        load_write(1, 1, 31);
        adv_valid = 1'b1;
        adv_row   = 5'd2;
        @(posedge clk);
        #1;
        model_adv(2);
        model_write(1);
        checks++;
        if (wr_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dual_write_done: got %b required 1", wr_done);
        end
        wr_valid  = 1'b0;
        adv_valid = 1'b0;
        push_expect("wr_adv_same_row", 3);
        push_expect("dual_write_row1", 1);
        push_expect("dual_adv_row2", 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
            #1;
            checks++;
            if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                         e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                         id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        int   low_cnt;
        bit   bad_accept;
        bit   done_seen;
        // Back-to-back writes to rows 0..3, one per cycle.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            load_write(r, 200 + r, 64 + 4*r);
            wr_valid = 1'b1;
            @(posedge clk);
            #1;
            model_write(r);
            checks++;
            if (wr_done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL burst_write_done row %0d: got %b required 1", r, wr_done);
            end
        end
        // Clear with a write to row 5 held throughout.
        @(negedge clk);
        frame_clear = 1'b1;
        load_write(5, 300, 80);
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_ready_comb: got %b required 0", wr_ready);
        end
        @(posedge clk);
        #1;
        frame_clear = 1'b0;
        low_cnt    = 0;
        bad_accept = 1'b0;
        done_seen  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (wr_done) bad_accept = 1'b1;
            if (k == 1) begin
                checks++;
                if (id_valid[1:0] !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL clear_partial: got id_valid[1:0]=%b required 10", id_valid[1:0]);
                end
            end
            if (wr_ready) begin
                done_seen = clear_done;
                break;
            end
            low_cnt++;
        end
        checks++;
        if (low_cnt !== 32 || done_seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_length: got %0d low cycles done=%b required 32 done=1", low_cnt, done_seen);
        end
        checks++;
        if (id_valid !== '0 || bad_accept !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_result: got id_valid=%h accepted=%b required 0/0", id_valid, bad_accept);
        end
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if ({wr_done, clear_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL held_write: got wr_done/clear_done=%b required 10", {wr_done, clear_done});
        end
        wr_valid = 1'b0;
        model_write(5);
        push_expect("held_write_row5", 5);
        push_expect("cleared_row0", 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
            #1;
            checks++;
            if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                         e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                         id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
            end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        int   done_k;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) load_write(4, 400, 90);
            else load_write(20, 500, 40);
            wr_valid = 1'b1;
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
        end
        @(negedge clk);
        frame_clear = 1'b1;
        @(posedge clk);
        #1;
        frame_clear = 1'b0;
        done_k = -1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            adv_valid   = (k == 2);
            adv_row     = 5'd20;
            frame_clear = (k == 11);
            @(posedge clk);
            #1;
            if (k == 2) begin
                cr_row = 5'd20;
                #1;
                checks++;
                if ({cr_id, cr_exhausted} !== {12'd40, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL adv_in_clear: got id=%h exh=%b required 028/0", cr_id, cr_exhausted);
                end
            end
            if (clear_done && done_k < 0) done_k = k;
            if (done_k >= 0) break;
        end
        adv_valid   = 1'b0;
        frame_clear = 1'b0;
        checks++;
        if (done_k !== 43) begin
            errors++;
            $display("[TB] FAIL restart_done: got clear_done at cycle %0d required 43", done_k);
        end
        model_clear();
        push_expect("restart_row20", 20);
        push_expect("restart_row4", 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
            #1;
            checks++;
            if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                         e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                         id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   bad;
        @(negedge clk);
        load_write(7, 600, 100);
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        model_write(7);
        @(negedge clk);
        frame_clear = 1'b1;
        @(posedge clk);
        #1;
        frame_clear = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        cr_row  = 5'd7;
        buf_row = 5'd7;
        load_write(8, 700, 110);
        wr_valid = 1'b1;
        reset_N  = 1'b0;
        #1;
        checks++;
        if ({wr_ready, wr_done, clear_done, cr_exhausted} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got rdy/done/cdone/exh=%b required 1000",
                     {wr_ready, wr_done, clear_done, cr_exhausted});
        end
        checks++;
        if (cr_score !== 16'hFFFF || cr_id !== 12'd0 || buf_id !== 12'd0) begin
            errors++;
            $display("[TB] FAIL midreset_read: got score=%h id=%h buf=%h required ffff/000/000",
                     cr_score, cr_id, buf_id);
        end
        checks++;
        if (id_valid !== '0 || id_out !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_ids: got id_valid=%h required 0", id_valid);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        reset_N = 1'b1;
        model_clear();
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (clear_done || !wr_ready) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_idle: got sweep activity=%b required 0", bad);
        end
        @(negedge clk);
        load_write(9, 800, 120);
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        model_write(9);
        push_expect("post_reset_row9", 9);
        push_expect("post_reset_row7", 7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cr_row = ROW_W'(e.row); buf_row = ROW_W'(e.row);
            #1;
            checks++;
            if ({cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row], id_out[e.row*ID_W +: ID_W]}
                !== {e.score, e.id, e.exh, e.id, e.idv, e.id}) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got score=%h id=%h exh=%b buf=%h idv=%b out=%h required score=%h id=%h exh=%b idv=%b",
                         e.tag, e.row, cr_score, cr_id, cr_exhausted, buf_id, id_valid[e.row],
                         id_out[e.row*ID_W +: ID_W], e.score, e.id, e.exh, e.idv);
            end
        end
    endtask

    initial begin
        reset_N     = 1'b0;
        frame_clear = 1'b0;
        wr_valid    = 1'b0;
        wr_row      = '0;
        wr_scores   = '0;
        wr_ids      = '0;
        adv_valid   = 1'b0;
        adv_row     = '0;
        cr_row      = '0;
        buf_row     = '0;
        model_clear();
        test_reset();
        test_write();
        test_back_to_back();
        test_same_cycle();
        test_clear();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000 required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
